i2cmb_wb_ctrl: RTL and testbench

- Wishbone-slave register front end of the I2C multi-bus master (i2cmb).
- Decodes CSR/DPR/CMDR/FSMR accesses from the wb agent side.
- Issues byte-level commands downstream to the byte FSM over a valid/ready handshake, then collects the completion status and read data.
- Generates the interrupt that the wb agent and the i2cmb predictor observe.

---
 rtl/i2cmb_wb_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_i2cmb_wb_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_ctrl.sv
// -----------------------------------------------------------------------------
// i2cmb_wb_ctrl
//
// Wishbone-slave register front end of the I2C multi-bus master. It decodes
// the four byte-wide registers (CSR, DPR, CMDR, FSMR), issues one byte-level
// command at a time to the byte FSM, collects the completion status and read
// data, and drives the level interrupt.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i       Wishbone cycle / strobe / write enable
//   adr_i[1:0]               0=CSR 1=DPR 2=CMDR 3=FSMR
//   dat_i[7:0], dat_o[7:0]   Wishbone write / read data (dat_o registered)
//   ack_o                    one-cycle acknowledge, one cycle after the strobe
//   irq_o                    level interrupt, masked by CSR.IE
//   cmd_valid_o/cmd_ready_i  byte command handshake
//   cmd_code_o, cmd_data_o   command code and operand (DPR snapshot)
//   rsp_valid_i              one-cycle completion pulse
//   rsp_status_i, rsp_data_i completion status (DON/NAK/AL/ERR) and read byte
//   bus_busy_i, bus_captured_i, fsm_state_i   status reflected into CSR/FSMR
//
// Command handshake: cmd_valid_o is high for the whole ISSUE state and the
// code/data stay stable while it is high; a command transfers on the rising
// edge where cmd_valid_o and cmd_ready_i are both high. cmd_valid_o never
// drops without a transfer except when the command is aborted (CSR.E cleared)
// or on reset.
// -----------------------------------------------------------------------------
module i2cmb_wb_ctrl #(
   parameter int NUM_BUSES = 1,
   parameter int BUS_ID_W  = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cyc_i,
   input  logic       stb_i,
   input  logic       we_i,
   input  logic [1:0] adr_i,
   input  logic [7:0] dat_i,
   output logic [7:0] dat_o,
   output logic       ack_o,
   output logic       irq_o,
   output logic       cmd_valid_o,
   input  logic       cmd_ready_i,
   output logic [2:0] cmd_code_o,
   output logic [7:0] cmd_data_o,
   input  logic       rsp_valid_i,
   input  logic [1:0] rsp_status_i,
   input  logic [7:0] rsp_data_i,
   input  logic       bus_busy_i,
   input  logic       bus_captured_i,
   input  logic [7:0] fsm_state_i
);

   localparam logic [1:0] ADR_CSR  = 2'd0;
   localparam logic [1:0] ADR_DPR  = 2'd1;
   localparam logic [1:0] ADR_CMDR = 2'd2;
   localparam logic [1:0] ADR_FSMR = 2'd3;

   localparam logic [2:0] CMD_READ_ACK = 3'b010;
   localparam logic [2:0] CMD_READ_NAK = 3'b011;
   localparam logic [2:0] CMD_SET_BUS  = 3'b110;

   localparam logic [1:0] RSP_DON = 2'd0;
   localparam logic [1:0] RSP_NAK = 2'd1;
   localparam logic [1:0] RSP_AL  = 2'd2;
   localparam logic [1:0] RSP_ERR = 2'd3;

   localparam logic [8:0] NUM_BUSES_C = 9'(NUM_BUSES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                ack_q, ack_d;
   logic [7:0]          dat_q, dat_d;
   logic                e_q, e_d;
   logic                ie_q, ie_d;
   logic [BUS_ID_W-1:0] bus_id_q, bus_id_d;
   logic [7:0]          dpr_q, dpr_d;
   logic                don_q, don_d;
   logic                nak_q, nak_d;
   logic                al_q, al_d;
   logic                err_q, err_d;
   logic [2:0]          cmd_q, cmd_d;
   logic [2:0]          cmd_code_q, cmd_code_d;
   logic [7:0]          cmd_data_q, cmd_data_d;
   logic                irq_q, irq_d;

   logic       xfer;
   logic       wr_csr, wr_dpr, wr_cmdr;
   logic       abort;
   logic       bad_bus;
   logic [7:0] rd_data;

   // A transfer is only accepted while no ack is outstanding, which gives the
   // one-cycle latency and prevents back-to-back acks.
   assign xfer    = cyc_i & stb_i & ~ack_q;
   assign wr_csr  = xfer & we_i & (adr_i == ADR_CSR);
   assign wr_dpr  = xfer & we_i & (adr_i == ADR_DPR);
   assign wr_cmdr = xfer & we_i & (adr_i == ADR_CMDR);

   // Clearing E while a command is in flight abandons it.
   assign abort   = wr_csr & ~dat_i[7] & (state_q != ST_IDLE);

   assign bad_bus = ({1'b0, dpr_q} >= NUM_BUSES_C);

   always_comb begin
      rd_data = 8'h00;
      unique case (adr_i)
         ADR_CSR:  rd_data = {e_q, ie_q, bus_busy_i, bus_captured_i, bus_id_q};
         ADR_DPR:  rd_data = dpr_q;
         ADR_CMDR: rd_data = {don_q, nak_q, al_q, err_q, 1'b0, cmd_q};
         ADR_FSMR: rd_data = fsm_state_i;
         default:  rd_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ack_d      = xfer;
      dat_d      = dat_q;
      e_d        = e_q;
      ie_d       = ie_q;
      bus_id_d   = bus_id_q;
      dpr_d      = dpr_q;
      don_d      = don_q;
      nak_d      = nak_q;
      al_d       = al_q;
      err_d      = err_q;
      cmd_d      = cmd_q;
      cmd_code_d = cmd_code_q;
      cmd_data_d = cmd_data_q;
      irq_d      = irq_q;

      // Register reads; reading CMDR acknowledges the interrupt.
      if (xfer && !we_i) begin
         dat_d = rd_data;
         if (adr_i == ADR_CMDR) begin
            irq_d = 1'b0;
         end
      end

      if (wr_csr) begin
         e_d  = dat_i[7];
         ie_d = dat_i[6];
         if (!dat_i[7]) begin
            bus_id_d = '0;
         end
      end

      if (wr_dpr) begin
         dpr_d = dat_i;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (wr_cmdr && e_q) begin
               cmd_d = dat_i[2:0];
               if (dat_i[2:0] == CMD_SET_BUS && bad_bus) begin
                  // Illegal bus ID: report ERR locally, nothing goes downstream.
                  don_d = 1'b0;
                  nak_d = 1'b0;
                  al_d  = 1'b0;
                  err_d = 1'b1;
                  irq_d = ie_q;
               end else begin
                  don_d      = 1'b0;
                  nak_d      = 1'b0;
                  al_d       = 1'b0;
                  err_d      = 1'b0;
                  irq_d      = 1'b0;
                  cmd_code_d = dat_i[2:0];
                  cmd_data_d = dpr_q;
                  state_d    = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            if (cmd_ready_i) begin
               state_d = ST_PENDING;
            end
         end

         ST_PENDING: begin
            if (rsp_valid_i) begin
               unique case (rsp_status_i)
                  RSP_DON: don_d = 1'b1;
                  RSP_NAK: nak_d = 1'b1;
                  RSP_AL:  al_d  = 1'b1;
                  RSP_ERR: err_d = 1'b1;
                  default: err_d = 1'b1;
               endcase
               if (rsp_status_i == RSP_DON) begin
                  // Received byte takes priority over a same-cycle DPR write.
                  if (cmd_code_q == CMD_READ_ACK || cmd_code_q == CMD_READ_NAK) begin
                     dpr_d = rsp_data_i;
                  end
                  if (cmd_code_q == CMD_SET_BUS) begin
                     bus_id_d = cmd_data_q[BUS_ID_W-1:0];
                  end
               end
               if (ie_q) begin
                  irq_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Abort overrides any handshake or response in the same cycle.
      if (abort) begin
         state_d = ST_IDLE;
         don_d   = 1'b1;
         nak_d   = 1'b0;
         al_d    = 1'b0;
         err_d   = 1'b0;
         cmd_d   = 3'b000;
         irq_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         ack_q      <= 1'b0;
         dat_q      <= 8'h00;
         e_q        <= 1'b0;
         ie_q       <= 1'b0;
         bus_id_q   <= '0;
         dpr_q      <= 8'h00;
         don_q      <= 1'b1;
         nak_q      <= 1'b0;
         al_q       <= 1'b0;
         err_q      <= 1'b0;
         cmd_q      <= 3'b000;
         cmd_code_q <= 3'b000;
         cmd_data_q <= 8'h00;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         e_q        <= e_d;
         ie_q       <= ie_d;
         bus_id_q   <= bus_id_d;
         dpr_q      <= dpr_d;
         don_q      <= don_d;
         nak_q      <= nak_d;
         al_q       <= al_d;
         err_q      <= err_d;
         cmd_q      <= cmd_d;
         cmd_code_q <= cmd_code_d;
         cmd_data_q <= cmd_data_d;
         irq_q      <= irq_d;
      end
   end

   assign dat_o       = dat_q;
   assign ack_o       = ack_q;
   // IE masks a pending interrupt without forgetting it.
   assign irq_o       = irq_q & ie_q;
   assign cmd_valid_o = (state_q == ST_ISSUE);
   assign cmd_code_o  = cmd_code_q;
   assign cmd_data_o  = cmd_data_q;

endmodule

// File: tb/tb_i2cmb_wb_ctrl.sv
module tb_i2cmb_wb_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [1:0] adr = 2'd0;
   logic [7:0] wdat = 8'h00;
   logic [7:0] dat_o;
   logic       ack_o, irq_o, cmd_valid_o;
   logic       cmd_ready = 1'b0;
   logic [2:0] cmd_code_o;
   logic [7:0] cmd_data_o;
   logic       rsp_valid = 1'b0;
   logic [1:0] rsp_status = 2'd0;
   logic [7:0] rsp_data = 8'h00;
   logic       bus_busy = 1'b0, bus_cap = 1'b0;
   logic [7:0] fsm_state = 8'h3C;

   int checks = 0;
   int errors = 0;
   int vld_cnt = 0;
   logic rd_flag = 1'b0;

   logic [7:0]  exp_q[$];
   string       name_q[$];
   logic [10:0] cmd_exp_q[$];

   i2cmb_wb_ctrl #(.NUM_BUSES(1), .BUS_ID_W(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(wdat),
      .dat_o(dat_o), .ack_o(ack_o), .irq_o(irq_o),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready),
      .cmd_code_o(cmd_code_o), .cmd_data_o(cmd_data_o),
      .rsp_valid_i(rsp_valid), .rsp_status_i(rsp_status), .rsp_data_i(rsp_data),
      .bus_busy_i(bus_busy), .bus_captured_i(bus_cap), .fsm_state_i(fsm_state)
   );

   // ---------------- clock / reset / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Read-data scoreboard: pops whenever the DUT acks a read.
   always @(negedge clk) begin
      if (ack_o && rd_flag) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got 0x%0h expected no read ack", dat_o);
         end else begin
            chk(name_q.pop_front(), {8'h00, dat_o}, {8'h00, exp_q.pop_front()});
         end
      end
   end

   // Command scoreboard: pops on every command handshake.
   always @(negedge clk) begin
      if (cmd_valid_o) vld_cnt++;
      if (cmd_valid_o && cmd_ready) begin
         if (cmd_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected: got code %0d data 0x%0h expected no command",
                     cmd_code_o, cmd_data_o);
         end else begin
            chk("cmd_issue", {5'd0, cmd_code_o, cmd_data_o}, {5'd0, cmd_exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; rd_flag = ~w;
      @(negedge clk);
      chk("ack_early", {15'd0, ack_o}, 16'd0);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("ack_pulse", {15'd0, ack_o}, 16'd1);
      @(posedge clk); #1;
      chk("ack_drop", {15'd0, ack_o}, 16'd0);
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
      wb_xfer(1'b1, a, d);
   endtask

   task automatic wb_read(input logic [1:0] a, input logic [7:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      wb_xfer(1'b0, a, 8'h00);
   endtask

   task automatic handshake(input int hold);
      int t = 0;
      while (!cmd_valid_o && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("cmd_valid_wait", {15'd0, cmd_valid_o}, 16'd1);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      chk("cmd_valid_drop", {15'd0, cmd_valid_o}, 16'd0);
   endtask

   task automatic respond(input logic [1:0] st, input logic [7:0] d);
      @(posedge clk); #1;
      rsp_valid = 1'b1; rsp_status = st; rsp_data = d;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
   endtask

   task automatic issue(input logic [2:0] code, input logic [7:0] data, input int hold,
                        input logic [1:0] st, input logic [7:0] rd);
      cmd_exp_q.push_back({code, data});
      wb_write(2'd2, {5'd0, code});
      handshake(hold);
      respond(st, rd);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {15'd0, ack_o}, 16'd0);
      chk("rst_irq", {15'd0, irq_o}, 16'd0);
      chk("rst_valid", {15'd0, cmd_valid_o}, 16'd0);
      chk("rst_code_data", {5'd0, cmd_code_o, cmd_data_o}, 16'd0);
      rst_n = 1'b1;

      wb_read(2'd0, 8'h00, "rst_csr");
      wb_read(2'd1, 8'h00, "rst_dpr");
      wb_read(2'd2, 8'h80, "rst_cmdr");
      wb_read(2'd3, 8'h3C, "fsmr");

      wb_write(2'd0, 8'hC0);
      wb_read(2'd0, 8'hC0, "csr_enable");
      bus_busy = 1'b1; bus_cap = 1'b1;
      wb_read(2'd0, 8'hF0, "csr_bb_bc");
      bus_busy = 1'b0; bus_cap = 1'b0;

      // WRITE with ready held low: valid high for 4 cycles.
      wb_write(2'd1, 8'h5A);
      vld_cnt = 0;
      cmd_exp_q.push_back({3'd1, 8'h5A});
      wb_write(2'd2, 8'h01);
      handshake(2);
      chk("valid_cycles", 16'(vld_cnt), 16'd4);
      chk("irq_pending", {15'd0, irq_o}, 16'd0);
      respond(2'd0, 8'h00);
      chk("irq_done", {15'd0, irq_o}, 16'd1);
      wb_read(2'd2, 8'h81, "cmdr_write_don");
      chk("irq_rd_clear", {15'd0, irq_o}, 16'd0);

      // READ_NAK with DON then with NAK.
      issue(3'd3, 8'h5A, 0, 2'd0, 8'hA7);
      wb_read(2'd1, 8'hA7, "dpr_read_byte");
      wb_read(2'd2, 8'h83, "cmdr_read_don");
      issue(3'd3, 8'hA7, 1, 2'd1, 8'h11);
      wb_read(2'd2, 8'h43, "cmdr_read_nak");
      wb_read(2'd1, 8'hA7, "dpr_nak_keep");

      // AL and ERR status bits.
      issue(3'd1, 8'hA7, 0, 2'd2, 8'h00);
      wb_read(2'd2, 8'h21, "cmdr_al");
      issue(3'd4, 8'hA7, 0, 2'd3, 8'h00);
      wb_read(2'd2, 8'h14, "cmdr_err");

      // SET_BUS legal, then illegal.
      wb_write(2'd1, 8'h00);
      issue(3'd6, 8'h00, 0, 2'd0, 8'h00);
      wb_read(2'd2, 8'h86, "cmdr_setbus_ok");
      wb_read(2'd0, 8'hC0, "csr_bus0");
      wb_write(2'd1, 8'h05);
      vld_cnt = 0;
      wb_write(2'd2, 8'h06);
      chk("irq_setbus_err", {15'd0, irq_o}, 16'd1);
      wb_read(2'd2, 8'h16, "cmdr_setbus_err");
      chk("irq_setbus_clr", {15'd0, irq_o}, 16'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("setbus_no_issue", 16'(vld_cnt), 16'd0);

      // CMDR write while PENDING is ignored.
      wb_write(2'd1, 8'h33);
      cmd_exp_q.push_back({3'd1, 8'h33});
      wb_write(2'd2, 8'h01);
      handshake(0);
      wb_write(2'd2, 8'h02);
      wb_read(2'd2, 8'h01, "cmdr_pending");
      respond(2'd0, 8'h00);
      wb_read(2'd2, 8'h81, "cmdr_after_ignore");
      // Stray response in IDLE.
      respond(2'd1, 8'h77);
      wb_read(2'd2, 8'h81, "cmdr_stray_rsp");
      wb_read(2'd1, 8'h33, "dpr_stray_rsp");
      chk("irq_stray", {15'd0, irq_o}, 16'd0);

      // DPR write during ISSUE leaves the operand alone.
      wb_write(2'd1, 8'h44);
      cmd_exp_q.push_back({3'd1, 8'h44});
      wb_write(2'd2, 8'h01);
      wb_write(2'd1, 8'h99);
      chk("cmd_data_stable", {8'd0, cmd_data_o}, 16'h0044);
      handshake(0);
      respond(2'd0, 8'h00);
      wb_read(2'd1, 8'h99, "dpr_during_issue");
      wb_read(2'd2, 8'h81, "cmdr_dpr_issue");

      // Response and CMDR write in the same cycle: response wins.
      cmd_exp_q.push_back({3'd1, 8'h99});
      wb_write(2'd2, 8'h01);
      handshake(0);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd2; wdat = 8'h02; rd_flag = 1'b0;
      rsp_valid = 1'b1; rsp_status = 2'd0;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; rsp_valid = 1'b0;
      @(posedge clk); #1;
      chk("collide_no_issue", {15'd0, cmd_valid_o}, 16'd0);
      wb_read(2'd2, 8'h81, "cmdr_collide");

      // Clearing E during PENDING aborts.
      cmd_exp_q.push_back({3'd1, 8'h99});
      wb_write(2'd2, 8'h01);
      handshake(0);
      wb_write(2'd0, 8'h40);
      chk("irq_abort", {15'd0, irq_o}, 16'd0);
      wb_read(2'd2, 8'h80, "cmdr_abort");
      respond(2'd0, 8'h00);
      wb_read(2'd2, 8'h80, "cmdr_abort_rsp");
      wb_read(2'd0, 8'h40, "csr_disabled");
      vld_cnt = 0;
      wb_write(2'd2, 8'h01);
      wb_read(2'd2, 8'h80, "cmdr_e0_write");
      chk("e0_no_issue", 16'(vld_cnt), 16'd0);

      // IE masks a pending interrupt combinationally.
      wb_write(2'd0, 8'hC0);
      issue(3'd1, 8'h99, 0, 2'd0, 8'h00);
      chk("irq_set", {15'd0, irq_o}, 16'd1);
      wb_write(2'd0, 8'h80);
      chk("irq_masked", {15'd0, irq_o}, 16'd0);
      wb_write(2'd0, 8'hC0);
      chk("irq_unmasked", {15'd0, irq_o}, 16'd1);
      wb_read(2'd2, 8'h81, "cmdr_mask");
      chk("irq_mask_clr", {15'd0, irq_o}, 16'd0);

      // Asynchronous reset in the middle of ISSUE.
      wb_write(2'd1, 8'h12);
      wb_write(2'd2, 8'h01);
      chk("issue_before_rst", {4'd0, cmd_valid_o, cmd_code_o, cmd_data_o}, 16'h0912);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_valid", {15'd0, cmd_valid_o}, 16'd0);
      chk("async_code_data", {5'd0, cmd_code_o, cmd_data_o}, 16'd0);
      chk("async_ack_irq", {14'd0, ack_o, irq_o}, 16'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wb_read(2'd0, 8'h00, "csr_after_rst");
      wb_read(2'd1, 8'h00, "dpr_after_rst");
      wb_read(2'd2, 8'h80, "cmdr_after_rst");

      repeat (3) @(posedge clk);
      #1;
      chk("rd_queue_empty", 16'(exp_q.size()), 16'd0);
      chk("cmd_queue_empty", 16'(cmd_exp_q.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
